// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory load/store unit: memop encodings,
// byte-lane write masks and the request FSM state type.
package mem_pkg;

  // Memory operation encodings carried on req_memop
  localparam logic [2:0] MEMOP_B  = 3'b000;
  localparam logic [2:0] MEMOP_H  = 3'b001;
  localparam logic [2:0] MEMOP_W  = 3'b010;
  localparam logic [2:0] MEMOP_BU = 3'b100;
  localparam logic [2:0] MEMOP_HU = 3'b101;

  // Byte-lane masks for a store at offset 0; shifted left by the byte offset
  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  // Request FSM: accept in IDLE, count latency in WAIT, hold result in RESP
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/data_mem_lsu_align.sv
// Combinational lane logic: decodes memop, checks alignment/legality, builds
// the store mask and shifted store data, and extracts/extends the load lane.
module lsu_align
  import mem_pkg::*;
#(
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic [2:0]  memop,
  input  logic        wen,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  wmask,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext,
  output logic        err
);

  logic       is_b;
  logic       is_h;
  logic       is_w;
  logic [1:0] eff_off;
  logic [3:0] base_mask;
  logic [31:0] lane;

  // Decode size, flag illegal/misaligned accesses and pick the effective offset
  always_comb begin
    is_b      = (memop == MEMOP_B) || (memop == MEMOP_BU);
    is_h      = (memop == MEMOP_H) || (memop == MEMOP_HU);
    is_w      = (memop == MEMOP_W);
    err       = 1'b0;
    eff_off   = off;
    base_mask = 4'b0000;
    if (!(is_b || is_h || is_w)) err = 1'b1;
    // Unsigned variants only make sense for loads
    if (wen && ((memop == MEMOP_BU) || (memop == MEMOP_HU))) err = 1'b1;
    if (CHECK_ALIGN) begin
      if (is_h && off[0])        err = 1'b1;
      if (is_w && (off != 2'b00)) err = 1'b1;
    end else if (is_h || is_w) begin
      // Without alignment checking, halfword/word ignore the low address bits
      eff_off = 2'b00;
    end
    if (is_b)      base_mask = MASK_B;
    else if (is_h) base_mask = MASK_H;
    else if (is_w) base_mask = MASK_W;
  end

  // Shift store data/mask into lane position and extend the load lane
  always_comb begin
    lane      = rword >> {eff_off, 3'b000};
    wdata_sh  = wdata << {eff_off, 3'b000};
    wmask     = err ? 4'b0000 : (base_mask << eff_off);
    rdata_ext = 32'h0;
    if (!err) begin
      case (memop)
        MEMOP_B:  rdata_ext = {{24{lane[7]}}, lane[7:0]};
        MEMOP_H:  rdata_ext = {{16{lane[15]}}, lane[15:0]};
        MEMOP_W:  rdata_ext = lane;
        MEMOP_BU: rdata_ext = {24'h0, lane[7:0]};
        MEMOP_HU: rdata_ext = {16'h0, lane[15:0]};
        default:  rdata_ext = 32'h0;
      endcase
    end
  end

endmodule

// File: rtl/data_mem_lsu.sv
// Load/store unit in front of the physical memory. One request at a time:
// accept, wait LATENCY cycles, perform one aligned word access, respond.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. req_* must stay stable while req_valid is high and req_ready
// is low; resp_* stay stable while resp_valid is high and resp_ready is low.
//
// The memory port behaves like a call interface: pmem_rd_en / pmem_wr_en are
// single-cycle strobes, one per accepted non-error request, and pmem_rdata
// is expected back combinationally in the same cycle as pmem_rd_en.
module data_mem_lsu
  import mem_pkg::*;
#(
  parameter int LATENCY     = 1,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_wen,
  input  logic [2:0]  req_memop,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        pmem_rd_en,
  output logic        pmem_wr_en,
  output logic [31:0] pmem_addr,
  output logic [31:0] pmem_wdata,
  output logic [3:0]  pmem_wmask,
  input  logic [31:0] pmem_rdata,
  output logic [1:0]  state_dbg
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t      state;
  logic [CW-1:0] cnt;
  logic [31:0] addr_q;
  logic        wen_q;
  logic [2:0]  memop_q;
  logic [31:0] wdata_q;

  logic        access;
  logic [3:0]  al_wmask;
  logic [31:0] al_wdata_sh;
  logic [31:0] al_rdata_ext;
  logic        al_err;

  lsu_align #(
    .CHECK_ALIGN(CHECK_ALIGN)
  ) u_align (
    .memop     (memop_q),
    .wen       (wen_q),
    .off       (addr_q[1:0]),
    .wdata     (wdata_q),
    .rword     (pmem_rdata),
    .wmask     (al_wmask),
    .wdata_sh  (al_wdata_sh),
    .rdata_ext (al_rdata_ext),
    .err       (al_err)
  );

  // Access cycle: last WAIT cycle; reset in this cycle drops the access
  assign access     = (state == ST_WAIT) && (cnt == '0) && !rst;
  assign pmem_rd_en = access && !al_err && !wen_q;
  assign pmem_wr_en = access && !al_err && wen_q;
  assign pmem_addr  = {addr_q[31:2], 2'b00};
  assign pmem_wdata = al_wdata_sh;
  assign pmem_wmask = al_wmask;
  assign state_dbg  = state;

  // Request FSM with latency counter and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      addr_q     <= 32'h0;
      wen_q      <= 1'b0;
      memop_q    <= 3'b000;
      wdata_q    <= 32'h0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            addr_q    <= req_addr;
            wen_q     <= req_wen;
            memop_q   <= req_memop;
            wdata_q   <= req_wdata;
            cnt       <= CW'(LATENCY - 1);
            req_ready <= 1'b0;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            resp_rdata <= (al_err || wen_q) ? 32'h0 : al_rdata_ext;
            resp_err   <= al_err;
            resp_valid <= 1'b1;
            state      <= ST_RESP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_RESP: begin
          // Return to IDLE only; the next request is accepted a cycle later
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed bench for data_mem_lsu: instance 0 uses LATENCY=3 with alignment
// checking, instance 1 uses LATENCY=1 without. A small word memory answers
// reads, and every memory strobe is counted and recorded.
module tb_data_mem_lsu;
  import mem_pkg::*;

  // Clock and reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]       req_valid, req_ready, req_wen, resp_valid, resp_ready, resp_err;
  logic [1:0]       pmem_rd_en, pmem_wr_en;
  logic [1:0][31:0] req_addr, req_wdata, resp_rdata, pmem_addr, pmem_wdata, pmem_rdata;
  logic [1:0][2:0]  req_memop;
  logic [1:0][3:0]  pmem_wmask;
  logic [1:0][1:0]  state_dbg;

  data_mem_lsu #(.LATENCY(3), .CHECK_ALIGN(1'b1)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
    .req_wen(req_wen[0]), .req_memop(req_memop[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]),
    .pmem_rd_en(pmem_rd_en[0]), .pmem_wr_en(pmem_wr_en[0]), .pmem_addr(pmem_addr[0]),
    .pmem_wdata(pmem_wdata[0]), .pmem_wmask(pmem_wmask[0]), .pmem_rdata(pmem_rdata[0]),
    .state_dbg(state_dbg[0])
  );

  data_mem_lsu #(.LATENCY(1), .CHECK_ALIGN(1'b0)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
    .req_wen(req_wen[1]), .req_memop(req_memop[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]),
    .pmem_rd_en(pmem_rd_en[1]), .pmem_wr_en(pmem_wr_en[1]), .pmem_addr(pmem_addr[1]),
    .pmem_wdata(pmem_wdata[1]), .pmem_wmask(pmem_wmask[1]), .pmem_rdata(pmem_rdata[1]),
    .state_dbg(state_dbg[1])
  );

  // Memory model: 16 words addressed by addr[5:2], read combinationally
  logic [31:0] mem [16];
  assign pmem_rdata[0] = mem[pmem_addr[0][5:2]];
  assign pmem_rdata[1] = mem[pmem_addr[1][5:2]];

  // Call recorder
  int          rd_calls [2];
  int          wr_calls [2];
  logic [31:0] last_waddr [2];
  logic [31:0] last_wdata [2];
  logic [3:0]  last_wmask [2];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (pmem_rd_en[d]) rd_calls[d] <= rd_calls[d] + 1;
      if (pmem_wr_en[d]) begin
        wr_calls[d]   <= wr_calls[d] + 1;
        last_waddr[d] <= pmem_addr[d];
        last_wdata[d] <= pmem_wdata[d];
        last_wmask[d] <= pmem_wmask[d];
      end
    end
  end

  // Scoreboard counters and the single checking task
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Driver: one full request/response transaction on instance d
  task automatic xact(input int d, input logic [31:0] addr, input logic wen,
                      input logic [2:0] memop, input logic [31:0] wdata,
                      input int hold, input logic [31:0] exp_hold,
                      output logic [31:0] rdata, output logic err, output int lat);
    @(negedge clk);
    req_valid[d] = 1'b1;
    req_addr[d]  = addr;
    req_wen[d]   = wen;
    req_memop[d] = memop;
    req_wdata[d] = wdata;
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
      if (resp_valid[d]) break;
    end
    rdata = resp_rdata[d];
    err   = resp_err[d];
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1;
      check("hold_rdata", resp_rdata[d], exp_hold);
      check("hold_valid", resp_valid[d], 1'b1);
      check("hold_req_ready", req_ready[d], 1'b0);
    end
    resp_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    resp_ready[d] = 1'b0;
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          r0, w0;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[0] = 32'h80FF_0102;
    mem[1] = 32'hDEAD_BEEF;
    rst        = 1'b1;
    req_valid  = '0;
    resp_ready = '0;
    req_wen    = '0;
    req_addr   = '0;
    req_wdata  = '0;
    req_memop  = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_req_ready", req_ready[0], 1'b1);
    check("rst_resp_valid", resp_valid[0], 1'b0);
    check("rst_resp_rdata", resp_rdata[0], 32'h0);
    check("rst_resp_err", resp_err[0], 1'b0);
    check("rst_state", state_dbg[0], ST_IDLE);

    // Loads on LATENCY=3 instance
    r0 = rd_calls[0];
    xact(0, 32'h8000_0003, 1'b0, MEMOP_B, 32'h0, 0, 32'h0, rd, er, lat);
    check("lb_data", rd, 32'hFFFF_FF80);
    check("lb_err", er, 1'b0);
    check("lb_latency", lat, 3);
    check("lb_calls", rd_calls[0] - r0, 1);

    xact(0, 32'h8000_0003, 1'b0, MEMOP_BU, 32'h0, 0, 32'h0, rd, er, lat);
    check("lbu_data", rd, 32'h0000_0080);
    check("lbu_err", er, 1'b0);
    xact(0, 32'h8000_0002, 1'b0, MEMOP_H, 32'h0, 0, 32'h0, rd, er, lat);
    check("lh_data", rd, 32'hFFFF_80FF);
    xact(0, 32'h8000_0000, 1'b0, MEMOP_HU, 32'h0, 0, 32'h0, rd, er, lat);
    check("lhu_data", rd, 32'h0000_0102);
    xact(0, 32'h8000_0000, 1'b0, MEMOP_W, 32'h0, 0, 32'h0, rd, er, lat);
    check("lw_data", rd, 32'h80FF_0102);

    // Halfword store into upper lanes
    r0 = rd_calls[0];
    w0 = wr_calls[0];
    xact(0, 32'h8000_0002, 1'b1, MEMOP_H, 32'h1234_ABCD, 0, 32'h0, rd, er, lat);
    check("sh_wcalls", wr_calls[0] - w0, 1);
    check("sh_rcalls", rd_calls[0] - r0, 0);
    check("sh_addr", last_waddr[0], 32'h8000_0000);
    check("sh_data", last_wdata[0], 32'hABCD_0000);
    check("sh_mask", last_wmask[0], 4'b1100);
    check("sh_rdata", rd, 32'h0);
    check("sh_err", er, 1'b0);

    // Error cases: no memory calls at all
    r0 = rd_calls[0];
    w0 = wr_calls[0];
    xact(0, 32'h8000_0002, 1'b0, MEMOP_W, 32'h0, 0, 32'h0, rd, er, lat);
    check("lw_mis_err", er, 1'b1);
    check("lw_mis_rdata", rd, 32'h0);
    xact(0, 32'h8000_0001, 1'b0, MEMOP_HU, 32'h0, 0, 32'h0, rd, er, lat);
    check("lhu_mis_err", er, 1'b1);
    check("lhu_mis_rdata", rd, 32'h0);
    xact(0, 32'h8000_0000, 1'b1, MEMOP_BU, 32'h55, 0, 32'h0, rd, er, lat);
    check("sbu_err", er, 1'b1);
    xact(0, 32'h8000_0000, 1'b0, 3'b111, 32'h0, 0, 32'h0, rd, er, lat);
    check("op111_err", er, 1'b1);
    check("op111_rdata", rd, 32'h0);
    check("err_calls", (rd_calls[0] - r0) + (wr_calls[0] - w0), 0);

    // Response held off for 5 cycles
    xact(0, 32'h8000_0004, 1'b0, MEMOP_W, 32'h0, 5, 32'hDEAD_BEEF, rd, er, lat);
    check("stall_data", rd, 32'hDEAD_BEEF);
    check("stall_latency", lat, 3);

    // Back-to-back loads
    r0 = rd_calls[0];
    xact(0, 32'h8000_0004, 1'b0, MEMOP_W, 32'h0, 0, 32'h0, rd, er, lat);
    check("b2b_lw0", rd, 32'hDEAD_BEEF);
    xact(0, 32'h8000_0000, 1'b0, MEMOP_W, 32'h0, 0, 32'h0, rd, er, lat);
    check("b2b_lw1", rd, 32'h80FF_0102);
    check("b2b_calls", rd_calls[0] - r0, 2);

    // Reset on the access cycle of a store drops it
    w0 = wr_calls[0];
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_addr[0]  = 32'h8000_0000;
    req_wen[0]   = 1'b1;
    req_memop[0] = MEMOP_W;
    req_wdata[0] = 32'h0000_0055;
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("wait_state", state_dbg[0], ST_WAIT);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("rstwait_req_ready", req_ready[0], 1'b1);
    check("rstwait_resp_valid", resp_valid[0], 1'b0);
    check("rstwait_state", state_dbg[0], ST_IDLE);
    repeat (4) @(posedge clk);
    #1;
    check("rstwait_wcalls", wr_calls[0] - w0, 0);
    check("rstwait_idle_valid", resp_valid[0], 1'b0);

    // Reset dominates a request in the same cycle
    r0 = rd_calls[0];
    @(negedge clk);
    rst          = 1'b1;
    req_valid[0] = 1'b1;
    req_addr[0]  = 32'h8000_0000;
    req_wen[0]   = 1'b0;
    req_memop[0] = MEMOP_W;
    @(posedge clk);
    #1;
    rst          = 1'b0;
    req_valid[0] = 1'b0;
    check("rstreq_state", state_dbg[0], ST_IDLE);
    check("rstreq_req_ready", req_ready[0], 1'b1);
    repeat (5) @(posedge clk);
    #1;
    check("rstreq_resp_valid", resp_valid[0], 1'b0);
    check("rstreq_calls", rd_calls[0] - r0, 0);

    // LATENCY=1, no alignment checking
    xact(1, 32'h8000_0006, 1'b0, MEMOP_W, 32'h0, 0, 32'h0, rd, er, lat);
    check("na_lw_data", rd, 32'hDEAD_BEEF);
    check("na_lw_err", er, 1'b0);
    check("na_lw_latency", lat, 1);
    xact(1, 32'h8000_0007, 1'b0, MEMOP_H, 32'h0, 0, 32'h0, rd, er, lat);
    check("na_lh_data", rd, 32'hFFFF_BEEF);
    xact(1, 32'h8000_0007, 1'b0, MEMOP_B, 32'h0, 0, 32'h0, rd, er, lat);
    check("na_lb_data", rd, 32'hFFFF_FFDE);
    w0 = wr_calls[1];
    xact(1, 32'hFFFF_FFFE, 1'b1, MEMOP_W, 32'hCAFE_F00D, 0, 32'h0, rd, er, lat);
    check("na_sw_calls", wr_calls[1] - w0, 1);
    check("na_sw_addr", last_waddr[1], 32'hFFFF_FFFC);
    check("na_sw_data", last_wdata[1], 32'hCAFE_F00D);
    check("na_sw_mask", last_wmask[1], 4'b1111);
    r0 = rd_calls[1];
    xact(1, 32'h8000_0000, 1'b0, 3'b110, 32'h0, 0, 32'h0, rd, er, lat);
    check("na_op110_err", er, 1'b1);
    check("na_op110_calls", rd_calls[1] - r0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
